prach_hb2_sched: RTL and testbench
==================================

# prach_hb2_sched

Corner-turn scheduler in front of the PRACH HB2 halfband decimator channel. Upstream delivers the 32-channel TDM stream two samples per beat, phase-major: all even-phase samples first, then all odd-phase samples. This block buffers each frame in a ping-pong memory and replays it channel-major. Every output cycle carries the even/odd polyphase pair of one channel on `dout_dp2`/`dout_dp1`, with `dout_chn` and `sync_out` exactly as the HB2 channel expects.

## Interface
- `NumChannel`, 32: channels per frame; must be even, ≤ 256.
- `Width`, 16: sample width.
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `din_dq0` in Width: lane 0 sample.
- `din_dq1` in Width: lane 1 sample.
- `din_valid` in 1: beat valid.
- `sync_in` in 1: first beat of a frame; only meaningful with `din_valid`.
- `dout_dp1` out Width: odd-phase sample of channel `dout_chn`.
- `dout_dp2` out Width: even-phase sample of channel `dout_chn`.
- `dout_chn` out 8: output channel index.
- `dout_valid` out 1: output slot valid.
- `sync_out` out 1: high with channel 0 of each output frame.
- `err_sync` out 1: one-cycle pulse, frame restarted by an early `sync_in`.

## Operation
- Frame = `NumChannel` valid beats, B = `NumChannel/2`.
- Beat b < B: dq0 = even(ch 2b), dq1 = even(ch 2b+1).
- Beat b ≥ B: dq0 = odd(ch 2(b−B)), dq1 = odd(ch 2(b−B)+1).
- Invalid beats (`din_valid`=0) are ignored and do not advance the beat counter.
- Write FSM:
  - W_IDLE: waits for `sync_in`&`din_valid`; valid beats without sync are dropped silently.
  - W_IDLE → W_FILL: that beat is written as beat 0 of the current write bank.
  - W_FILL: `wcnt` advances per valid beat.
  - Beat `NumChannel−1` written: bank full flag set, write bank toggles, FSM → W_IDLE.
- Early sync: `sync_in`&`din_valid` in W_FILL with `wcnt`≠0 pulses `err_sync`, discards the partial frame and writes this beat as beat 0 of the same bank.
- Read FSM:
  - R_IDLE: moves to R_RUN when the read bank is full.
  - R_RUN: `rcnt` runs 0..`NumChannel−1`, one channel per cycle.
  - After the last channel the bank is released and the read bank toggles.
  - If the other bank is already full, R_RUN continues with no gap cycle.
- Output for channel c: `dout_dp2` = even(c), `dout_dp1` = odd(c), `dout_chn` = c, `dout_valid`=1, `sync_out` = (c==0).
- When not valid: `dout_dp1`/`dout_dp2`/`dout_chn`/`sync_out` = 0.
- Back-pressure: none; write can never lap read, because a bank fill takes ≥ `NumChannel` cycles and a bank read takes exactly `NumChannel`.

## Timing
- Reset (`rst_n`=0 at a clk edge):
  - both banks empty, both FSMs idle, all outputs 0 on the next cycle;
  - a frame in flight is lost;
  - memory contents are not cleared.
- Latency: last beat of a frame at edge t → `dout_valid`/`sync_out` for channel 0 at edge t+3; channel c at t+3+c.
- Continuous input (`din_valid` held 1, sync every `NumChannel` beats) gives continuous output (`dout_valid` held 1 after the first frame).
- Same-cycle bank release by read and bank-full by write on the other bank: both take effect, with no lost cycle.
- Sync on the beat right after a frame completes: normal frame start, no error.

## Structure
- Shared package `prach_pkg`:
  - `NumChannel` constant;
  - sample typedef `logic signed [15:0]`;
  - write and read FSM state enums.
- Sub-module `prach_pp_ram`: simple dual-port RAM, 1 write / 1 read port, registered read, `(* ramstyle = "mlab" *)`.
- Instantiate 4× `prach_pp_ram`, one per {even, odd}×{lane0, lane1}.
  - Each holds 2 banks × B entries; address = {bank, channel/2}.
  - Lane = channel LSB.
  - Read muxes by the registered channel LSB.

## Test plan
- Continuous frames with even(c)=0x1000+c, odd(c)=0x2000+c, 4 frames:
  - first `sync_out` exactly 3 cycles after the last beat of frame 0;
  - thereafter `dout_valid` stays 1;
  - slot c gives dp2=0x1000+c, dp1=0x2000+c, chn=c.
- `din_valid` toggling 1/0 within a frame: output identical to the continuous case, delayed by the stall; output has gaps between frames only.
- `sync_in` at beat 10 of a frame: `err_sync` pulses for one cycle; only the restarted frame is output, with correct data.
- Valid beats before any sync: no output and no error until the first sync frame completes.
- Reset asserted mid-read and mid-fill: outputs are 0 the next cycle; the next full frame after reset is output correctly at t+3.
- Back-to-back frames with no idle beat: no gap cycle between the last channel of one output frame and channel 0 of the next.

Source files
------------

// File: rtl/prach_pkg.sv
// Shared definitions for the PRACH HB2 front-end: channel count, sample type
// and the write/read FSM state encodings of the corner-turn scheduler.
package prach_pkg;

  localparam int NumChannel = 32;

  typedef logic signed [15:0] sample_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_FILL = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RUN  = 1'b1
  } rd_state_t;

endpackage

// File: rtl/prach_pp_ram.sv
// Simple dual-port RAM, one write and one registered read port.
// Contents are never reset.
module prach_pp_ram #(
  parameter int Width = 16,
  parameter int AddrW = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  (* ramstyle = "mlab" *) logic [Width-1:0] mem [2**AddrW];

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // registered read port
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/prach_hb2_sched.sv
// Corner-turn scheduler: buffers phase-major TDM frames in a ping-pong memory
// and replays them channel-major as even/odd polyphase pairs for the HB2 channel.
module prach_hb2_sched #(
  parameter int NumChannel = prach_pkg::NumChannel,
  parameter int Width      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] din_dq0,
  input  logic [Width-1:0] din_dq1,
  input  logic             din_valid,
  input  logic             sync_in,
  output logic [Width-1:0] dout_dp1,
  output logic [Width-1:0] dout_dp2,
  output logic [7:0]       dout_chn,
  output logic             dout_valid,
  output logic             sync_out,
  output logic             err_sync
);

  import prach_pkg::*;

  localparam int B  = NumChannel / 2;
  localparam int CW = $clog2(NumChannel);
  localparam int IW = $clog2(B);
  localparam int AW = IW + 1;
  localparam logic [CW-1:0] LastBeat = CW'(NumChannel - 1);
  localparam logic [CW-1:0] HalfBeat = CW'(B);

  wr_state_t        wstate;
  logic [CW-1:0]    wcnt;
  logic             wbank;
  rd_state_t        rstate;
  logic [CW-1:0]    rcnt;
  logic             rbank;
  logic [1:0]       full;
  logic [1:0]       full_set;
  logic [1:0]       full_clr;
  logic             wr_go;
  logic             wr_odd;
  logic             wr_done;
  logic             rd_done;
  logic             we_even;
  logic             we_odd;
  logic [CW-1:0]    wr_beat;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [Width-1:0] ev0, ev1, od0, od1;
  logic             v1;
  logic [CW-1:0]    chn1;

  // A sync beat always lands as beat 0, whether starting or restarting a frame
  always_comb begin
    wr_go    = din_valid & (sync_in | (wstate == W_FILL));
    wr_beat  = sync_in ? '0 : wcnt;
    wr_odd   = (wr_beat >= HalfBeat);
    wr_addr  = {wbank, IW'(wr_odd ? (wr_beat - HalfBeat) : wr_beat)};
    we_even  = wr_go & ~wr_odd;
    we_odd   = wr_go & wr_odd;
    wr_done  = wr_go & (wr_beat == LastBeat);
    rd_done  = (rstate == R_RUN) & (rcnt == LastBeat);
    rd_addr  = {rbank, IW'(rcnt >> 1)};
    full_set = wr_done ? (2'b01 << wbank) : 2'b00;
    full_clr = rd_done ? (2'b01 << rbank) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate   <= W_IDLE;
      wcnt     <= '0;
      wbank    <= 1'b0;
      err_sync <= 1'b0;
    end else begin
      err_sync <= din_valid & sync_in & (wstate == W_FILL) & (wcnt != '0);
      if (wr_go) begin
        if (wr_done) begin
          wstate <= W_IDLE;
          wcnt   <= '0;
          wbank  <= ~wbank;
        end else begin
          wstate <= W_FILL;
          wcnt   <= wr_beat + 1'b1;
        end
      end
    end
  end

  // release and fill always hit different banks, so both may land in one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 2'b00;
    end else begin
      full <= (full & ~full_clr) | full_set;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rstate <= R_IDLE;
      rcnt   <= '0;
      rbank  <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          rcnt <= '0;
          if (full[rbank]) begin
            rstate <= R_RUN;
          end
        end
        R_RUN: begin
          if (rcnt == LastBeat) begin
            rcnt  <= '0;
            rbank <= ~rbank;
            if (!full[~rbank]) begin
              rstate <= R_IDLE;
            end
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        default: begin
          rstate <= R_IDLE;
          rcnt   <= '0;
        end
      endcase
    end
  end

  // stage 1 tracks the slot alongside the RAM read; stage 2 drives the outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1         <= 1'b0;
      chn1       <= '0;
      dout_valid <= 1'b0;
      sync_out   <= 1'b0;
      dout_chn   <= 8'd0;
      dout_dp1   <= '0;
      dout_dp2   <= '0;
    end else begin
      v1   <= (rstate == R_RUN);
      chn1 <= rcnt;
      if (v1) begin
        dout_valid <= 1'b1;
        sync_out   <= (chn1 == '0);
        dout_chn   <= 8'(chn1);
        dout_dp2   <= chn1[0] ? ev1 : ev0;
        dout_dp1   <= chn1[0] ? od1 : od0;
      end else begin
        dout_valid <= 1'b0;
        sync_out   <= 1'b0;
        dout_chn   <= 8'd0;
        dout_dp1   <= '0;
        dout_dp2   <= '0;
      end
    end
  end

  prach_pp_ram #(.Width(Width), .AddrW(AW)) u_ram_ev0 (
    .clk(clk), .we(we_even), .waddr(wr_addr), .wdata(din_dq0), .raddr(rd_addr), .rdata(ev0)
  );
  prach_pp_ram #(.Width(Width), .AddrW(AW)) u_ram_ev1 (
    .clk(clk), .we(we_even), .waddr(wr_addr), .wdata(din_dq1), .raddr(rd_addr), .rdata(ev1)
  );
  prach_pp_ram #(.Width(Width), .AddrW(AW)) u_ram_od0 (
    .clk(clk), .we(we_odd), .waddr(wr_addr), .wdata(din_dq0), .raddr(rd_addr), .rdata(od0)
  );
  prach_pp_ram #(.Width(Width), .AddrW(AW)) u_ram_od1 (
    .clk(clk), .we(we_odd), .waddr(wr_addr), .wdata(din_dq1), .raddr(rd_addr), .rdata(od1)
  );

endmodule

// File: tb/tb_prach_hb2_sched.sv
// Directed bench for prach_hb2_sched: drives phase-major frames and checks every
// output cycle against an expected slot list built from each frame's last-beat edge.
module tb_prach_hb2_sched;

  localparam int N = 32;
  localparam int B = N / 2;

  typedef struct {
    int          cyc;
    logic [7:0]  chn;
    logic [15:0] dp2;
    logic [15:0] dp1;
  } slot_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] din_dq0;
  logic [15:0] din_dq1;
  logic        din_valid;
  logic        sync_in;
  logic [15:0] dout_dp1;
  logic [15:0] dout_dp2;
  logic [7:0]  dout_chn;
  logic        dout_valid;
  logic        sync_out;
  logic        err_sync;

  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  int    err_cnt = 0;
  int    err_cyc = -1;
  bit    mon_en = 1'b0;
  slot_t exp_q[$];

  prach_hb2_sched #(.NumChannel(N), .Width(16)) dut (
    .clk(clk), .rst_n(rst_n), .din_dq0(din_dq0), .din_dq1(din_dq1),
    .din_valid(din_valid), .sync_in(sync_in), .dout_dp1(dout_dp1),
    .dout_dp2(dout_dp2), .dout_chn(dout_chn), .dout_valid(dout_valid),
    .sync_out(sync_out), .err_sync(err_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // edge counter: after edge n settles, cyc == n
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] even_smp(input int f, input int c);
    return 16'(32'h1000 + f * 64 + c);
  endfunction

  function automatic logic [15:0] odd_smp(input int f, input int c);
    return 16'(32'h2000 + f * 64 + c);
  endfunction

  // output monitor: every cycle is either the next expected slot or all-zero idle
  always @(negedge clk) begin
    slot_t e;
    if (mon_en) begin
      if (err_sync) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_valid", 64'(dout_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("slot_cycle", 64'(cyc), 64'(e.cyc));
          check_val("slot_chn", 64'(dout_chn), 64'(e.chn));
          check_val("slot_dp2", 64'(dout_dp2), 64'(e.dp2));
          check_val("slot_dp1", 64'(dout_dp1), 64'(e.dp1));
          check_val("slot_sync", 64'(sync_out), 64'(e.chn == 8'd0));
        end
      end else begin
        check_val("idle_zero", 64'({dout_dp1, dout_dp2, dout_chn, sync_out}), 64'd0);
        if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          check_val("missing_slot", 64'(dout_valid), 64'd1);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic s, input logic [15:0] a,
                       input logic [15:0] b, output int t);
    din_valid = v;
    sync_in   = s;
    din_dq0   = a;
    din_dq1   = b;
    @(posedge clk);
    #1;
    t = cyc;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    sync_in   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int f, input bit stall, input int nbeats, output int t_first);
    int t;
    t = 0;
    t_first = 0;
    for (int b = 0; b < nbeats; b++) begin
      if (stall && b > 0) drive(1'b0, 1'b0, 16'h0, 16'h0, t);
      if (b < B) drive(1'b1, (b == 0), even_smp(f, 2 * b), even_smp(f, 2 * b + 1), t);
      else       drive(1'b1, 1'b0, odd_smp(f, 2 * (b - B)), odd_smp(f, 2 * (b - B) + 1), t);
      if (b == 0) t_first = t;
    end
    if (nbeats == N) begin
      for (int c = 0; c < N; c++) begin
        slot_t s;
        s.cyc = t + 3 + c;
        s.chn = 8'(c);
        s.dp2 = even_smp(f, c);
        s.dp1 = odd_smp(f, c);
        exp_q.push_back(s);
      end
    end
  endtask

  initial begin
    int t;
    int t_first;
    int err_before;
    int rst_edge;
    rst_n     = 1'b0;
    din_valid = 1'b0;
    sync_in   = 1'b0;
    din_dq0   = 16'h0;
    din_dq1   = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_valid", 64'(dout_valid), 64'd0);
    check_val("reset_sync", 64'(sync_out), 64'd0);
    check_val("reset_chn", 64'(dout_chn), 64'd0);
    check_val("reset_data", 64'({dout_dp1, dout_dp2}), 64'd0);
    check_val("reset_err", 64'(err_sync), 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // valid beats with no sync are dropped silently
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 16'hbeef, 16'hcafe, t);
    idle(40);
    check_val("nosync_err", 64'(err_cnt), 64'd0);

    // four back-to-back frames, each sync directly after the previous frame
    for (int f = 0; f < 4; f++) send_frame(f, 1'b0, N, t_first);
    idle(40);
    check_val("b2b_no_err", 64'(err_cnt), 64'd0);

    // valid toggling within frames
    send_frame(4, 1'b1, N, t_first);
    send_frame(5, 1'b1, N, t_first);
    idle(40);

    // early sync at beat 10 restarts the frame
    err_before = err_cnt;
    send_frame(6, 1'b0, 10, t_first);
    send_frame(7, 1'b0, N, t_first);
    check_val("early_err_count", 64'(err_cnt - err_before), 64'd1);
    check_val("early_err_cycle", 64'(err_cyc), 64'(t_first));
    idle(40);

    // reset while frame 8 is being read and frame 9 is filling
    send_frame(8, 1'b0, N, t_first);
    send_frame(9, 1'b0, 5, t_first);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    sync_in   = 1'b0;
    @(posedge clk);
    #1;
    rst_edge = cyc;
    while (exp_q.size() != 0 && exp_q[$].cyc >= rst_edge) void'(exp_q.pop_back());
    rst_n = 1'b1;
    check_val("rst_mid_out", 64'({dout_valid, sync_out, dout_chn, dout_dp1, dout_dp2}), 64'd0);
    idle(3);
    send_frame(10, 1'b0, N, t_first);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check_val("drain_pending", 64'(exp_q.size()), 64'd0);
    idle(5);
    check_val("final_err_total", 64'(err_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
